// File: rtl/gate_response_checker.sv
// Response checker for 2-input gate cells: compares each sampled vector against the
// latched truth table, tracks input coverage, counts mismatches and captures the first failure.
module gate_response_checker #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       func_sel,
  input  logic             vld,
  input  logic             in1,
  input  logic             in2,
  input  logic             out_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             fail_vld,
  output logic [1:0]       fail_vec,
  output logic             fail_obs
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] F_AND  = 2'b00;
  localparam logic [1:0] F_OR   = 2'b01;
  localparam logic [1:0] F_XOR  = 2'b10;

  state_t           state_q, state_d;
  logic [1:0]       func_q, func_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic             pass_q, pass_d;
  logic             fvld_q, fvld_d;
  logic [1:0]       fvec_q, fvec_d;
  logic             fobs_q, fobs_d;

  logic             exp_out;
  logic             mismatch;

  function automatic logic gate_eval(input logic [1:0] f, input logic a, input logic b);
    case (f)
      F_AND:   gate_eval = a & b;
      F_OR:    gate_eval = a | b;
      F_XOR:   gate_eval = a ^ b;
      default: gate_eval = ~(a & b);
    endcase
  endfunction

  // Counter sticks at all-ones so a long failing run never wraps back to a pass.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    sat_inc = (&v) ? v : v + ERR_W'(1);
  endfunction

  assign exp_out  = gate_eval(func_q, in1, in2);
  assign mismatch = (out_obs != exp_out);

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    err_d   = err_q;
    cov_d   = cov_q;
    pass_d  = pass_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;
    fobs_d  = fobs_q;

    case (state_q)
      S_CHECK: begin
        if (vld) begin
          cov_d = cov_q | (4'b0001 << {in1, in2});
          if (mismatch) begin
            err_d = sat_inc(err_q);
            if (!fvld_q) begin
              fvld_d = 1'b1;
              fvec_d = {in1, in2};
              fobs_d = out_obs;
            end
          end
          // The final sample's own mismatch must count toward the verdict.
          if (cov_d == 4'b1111) begin
            state_d = S_DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_CHECK;
          func_d  = func_sel;
          err_d   = '0;
          cov_d   = '0;
          pass_d  = 1'b0;
          fvld_d  = 1'b0;
          fvec_d  = '0;
          fobs_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      func_q  <= F_AND;
      err_q   <= '0;
      cov_q   <= '0;
      pass_q  <= 1'b0;
      fvld_q  <= 1'b0;
      fvec_q  <= '0;
      fobs_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      pass_q  <= pass_d;
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
      fobs_q  <= fobs_d;
    end
  end

  assign busy     = (state_q == S_CHECK);
  assign done     = (state_q == S_DONE);
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign cov      = cov_q;
  assign fail_vld = fvld_q;
  assign fail_vec = fvec_q;
  assign fail_obs = fobs_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: two instances (ERR_W=8 and ERR_W=2) share
// stimulus; a behavioural model queues the expected outputs for every driven cycle.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] func_sel;
  logic       vld, in1, in2, out_obs;

  logic       busy_a, done_a, pass_a, fvld_a, fobs_a;
  logic [7:0] err_a;
  logic [3:0] cov_a;
  logic [1:0] fvec_a;

  logic       busy_b, done_b, pass_b, fvld_b, fobs_b;
  logic [1:0] err_b;
  logic [3:0] cov_b;
  logic [1:0] fvec_b;

  always #5 clk = ~clk;

  gate_response_checker #(.ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .func_sel(func_sel), .vld(vld),
    .in1(in1), .in2(in2), .out_obs(out_obs),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .cov(cov_a),
    .fail_vld(fvld_a), .fail_vec(fvec_a), .fail_obs(fobs_a)
  );

  gate_response_checker #(.ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .func_sel(func_sel), .vld(vld),
    .in1(in1), .in2(in2), .out_obs(out_obs),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .cov(cov_b),
    .fail_vld(fvld_b), .fail_vec(fvec_b), .fail_obs(fobs_b)
  );

  // kind: 0 = idle cycle, 1 = start pulse, 2 = valid sample
  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] fs;
    logic       a;
    logic       b;
    logic       o;
  } step_t;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_state;
  logic [1:0] m_func;
  logic [3:0] m_cov;
  int         m_err;
  logic       m_pass, m_fvld, m_fobs;
  logic [1:0] m_fvec;

  logic [18:0] sb_a[$];
  logic [18:0] sb_b[$];

  function automatic logic ref_gate(input logic [1:0] f, input logic a, input logic b);
    case (f)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic logic [18:0] model_vec(input int cap);
    int e;
    e = (m_err > cap) ? cap : m_err;
    return {m_state == 1, m_state == 2, m_pass, m_cov, 8'(e), m_fvld, m_fvec, m_fobs};
  endfunction

  function automatic logic [18:0] obs_a();
    return {busy_a, done_a, pass_a, cov_a, err_a, fvld_a, fvec_a, fobs_a};
  endfunction

  function automatic logic [18:0] obs_b();
    return {busy_b, done_b, pass_b, cov_b, 6'd0, err_b, fvld_b, fvec_b, fobs_b};
  endfunction

  task automatic model_reset();
    m_state = 0; m_func = 2'b00; m_cov = 4'b0; m_err = 0;
    m_pass = 1'b0; m_fvld = 1'b0; m_fvec = 2'b0; m_fobs = 1'b0;
  endtask

  task automatic apply_step(input step_t s);
    logic e;
    @(negedge clk);
    start    = (s.kind == 2'd1);
    vld      = (s.kind == 2'd2);
    func_sel = s.fs;
    in1      = s.a;
    in2      = s.b;
    out_obs  = s.o;
    if (s.kind == 2'd1 && m_state != 1) begin
      m_state = 1; m_func = s.fs; m_cov = 4'b0; m_err = 0;
      m_pass = 1'b0; m_fvld = 1'b0; m_fvec = 2'b0; m_fobs = 1'b0;
    end else if (s.kind == 2'd2 && m_state == 1) begin
      e = ref_gate(m_func, s.a, s.b);
      m_cov[{s.a, s.b}] = 1'b1;
      if (s.o != e) begin
        m_err++;
        if (!m_fvld) begin
          m_fvld = 1'b1; m_fvec = {s.a, s.b}; m_fobs = s.o;
        end
      end
      if (m_cov == 4'b1111) begin
        m_state = 2;
        m_pass  = (m_err == 0);
      end
    end
    sb_a.push_back(model_vec(255));
    sb_b.push_back(model_vec(3));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; vld = 1'b0; func_sel = 2'b00;
    in1 = 1'b0; in2 = 1'b0; out_obs = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (obs_a() !== 19'd0) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs_a(), 19'd0);
    end
    n_checks++;
    if (obs_b() !== 19'd0) begin
      n_fail++; $display("FAIL reset_state_sat: got %h want %h", obs_b(), 19'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_and_pass();
    step_t st[5] = '{'{2'd1, 2'b00, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b11, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b01, 1'b0, 1'b1, 1'b0},
                     '{2'd2, 2'b10, 1'b1, 1'b0, 1'b0},
                     '{2'd2, 2'b11, 1'b1, 1'b1, 1'b1}};
    logic [18:0] ea, eb;
    foreach (st[i]) begin
      apply_step(st[i]);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_checks++;
      if (obs_a() !== ea) begin n_fail++; $display("FAIL and_pass[%0d]: got %h want %h", i, obs_a(), ea); end
      n_checks++;
      if (obs_b() !== eb) begin n_fail++; $display("FAIL and_pass_sat[%0d]: got %h want %h", i, obs_b(), eb); end
    end
  endtask

  task automatic test_and_stuck0();
    step_t st[6] = '{'{2'd1, 2'b00, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b00, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b00, 1'b0, 1'b1, 1'b0},
                     '{2'd2, 2'b00, 1'b1, 1'b0, 1'b0},
                     '{2'd2, 2'b00, 1'b1, 1'b1, 1'b0},
                     '{2'd2, 2'b00, 1'b1, 1'b1, 1'b1}};
    logic [18:0] ea, eb;
    foreach (st[i]) begin
      apply_step(st[i]);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_checks++;
      if (obs_a() !== ea) begin n_fail++; $display("FAIL and_stuck0[%0d]: got %h want %h", i, obs_a(), ea); end
      n_checks++;
      if (obs_b() !== eb) begin n_fail++; $display("FAIL and_stuck0_sat[%0d]: got %h want %h", i, obs_b(), eb); end
    end
  endtask

  task automatic test_xor_repeat();
    step_t st[7] = '{'{2'd1, 2'b10, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b00, 1'b0, 1'b0, 1'b1},
                     '{2'd0, 2'b01, 1'b1, 1'b1, 1'b0},
                     '{2'd2, 2'b01, 1'b0, 1'b1, 1'b0},
                     '{2'd2, 2'b11, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b00, 1'b1, 1'b0, 1'b1},
                     '{2'd2, 2'b01, 1'b1, 1'b1, 1'b0}};
    logic [18:0] ea, eb;
    foreach (st[i]) begin
      apply_step(st[i]);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_checks++;
      if (obs_a() !== ea) begin n_fail++; $display("FAIL xor_repeat[%0d]: got %h want %h", i, obs_a(), ea); end
      n_checks++;
      if (obs_b() !== eb) begin n_fail++; $display("FAIL xor_repeat_sat[%0d]: got %h want %h", i, obs_b(), eb); end
    end
  endtask

  task automatic test_nand_saturate();
    step_t st[7] = '{'{2'd1, 2'b11, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b00, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b01, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b10, 1'b0, 1'b1, 1'b0},
                     '{2'd2, 2'b00, 1'b0, 1'b1, 1'b0},
                     '{2'd2, 2'b01, 1'b1, 1'b0, 1'b0},
                     '{2'd2, 2'b10, 1'b1, 1'b1, 1'b1}};
    logic [18:0] ea, eb;
    foreach (st[i]) begin
      apply_step(st[i]);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_checks++;
      if (obs_a() !== ea) begin n_fail++; $display("FAIL nand_sat[%0d]: got %h want %h", i, obs_a(), ea); end
      n_checks++;
      if (obs_b() !== eb) begin n_fail++; $display("FAIL nand_sat_w2[%0d]: got %h want %h", i, obs_b(), eb); end
    end
  endtask

  task automatic test_reset_mid_run();
    step_t pre[3]  = '{'{2'd1, 2'b00, 1'b0, 1'b0, 1'b0},
                       '{2'd2, 2'b00, 1'b0, 1'b0, 1'b1},
                       '{2'd2, 2'b00, 1'b0, 1'b1, 1'b0}};
    step_t post[7] = '{'{2'd1, 2'b00, 1'b0, 1'b0, 1'b0},
                       '{2'd2, 2'b00, 1'b0, 1'b0, 1'b0},
                       '{2'd1, 2'b01, 1'b0, 1'b0, 1'b0},
                       '{2'd0, 2'b01, 1'b0, 1'b0, 1'b0},
                       '{2'd2, 2'b01, 1'b0, 1'b1, 1'b0},
                       '{2'd2, 2'b01, 1'b1, 1'b0, 1'b0},
                       '{2'd2, 2'b01, 1'b1, 1'b1, 1'b1}};
    logic [18:0] ea, eb;
    foreach (pre[i]) begin
      apply_step(pre[i]);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_checks++;
      if (obs_a() !== ea) begin n_fail++; $display("FAIL mid_pre[%0d]: got %h want %h", i, obs_a(), ea); end
      n_checks++;
      if (obs_b() !== eb) begin n_fail++; $display("FAIL mid_pre_sat[%0d]: got %h want %h", i, obs_b(), eb); end
    end
    @(negedge clk);
    start = 1'b0; vld = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs_a() !== 19'd0) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs_a(), 19'd0); end
    n_checks++;
    if (obs_b() !== 19'd0) begin n_fail++; $display("FAIL async_reset_sat: got %h want %h", obs_b(), 19'd0); end
    @(negedge clk);
    rst = 1'b0;
    foreach (post[i]) begin
      apply_step(post[i]);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_checks++;
      if (obs_a() !== ea) begin n_fail++; $display("FAIL mid_post[%0d]: got %h want %h", i, obs_a(), ea); end
      n_checks++;
      if (obs_b() !== eb) begin n_fail++; $display("FAIL mid_post_sat[%0d]: got %h want %h", i, obs_b(), eb); end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[7] = '{'{2'd2, 2'b00, 1'b1, 1'b1, 1'b0},
                     '{2'd0, 2'b00, 1'b0, 1'b0, 1'b0},
                     '{2'd1, 2'b01, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b00, 1'b0, 1'b0, 1'b0},
                     '{2'd2, 2'b10, 1'b0, 1'b1, 1'b1},
                     '{2'd2, 2'b11, 1'b1, 1'b0, 1'b1},
                     '{2'd2, 2'b00, 1'b1, 1'b1, 1'b1}};
    logic [18:0] ea, eb;
    foreach (st[i]) begin
      apply_step(st[i]);
      ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_checks++;
      if (obs_a() !== ea) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h want %h", i, obs_a(), ea); end
      n_checks++;
      if (obs_b() !== eb) begin n_fail++; $display("FAIL back_to_back_sat[%0d]: got %h want %h", i, obs_b(), eb); end
    end
  endtask

  initial begin
    test_reset();
    test_and_pass();
    test_and_stuck0();
    test_xor_repeat();
    test_nand_saturate();
    test_reset_mid_run();
    test_back_to_back();
    @(negedge clk);
    start = 1'b0; vld = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable response checker for 2-input gate cells. It is the receiving end of the gate-stimulus interface: a driver applies in1/in2 to a gate, and this block samples the applied vector and the gate's output. It compares each sample against the selected truth table, tracks coverage of all four input combinations, counts mismatches and captures the first failing vector. It replaces manual monitor-and-eyeball checking with a hardware pass/fail verdict.

Parameters:
ERR_W, 8, width of the mismatch counter (saturating).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a check run.
func_sel  input  2  expected function: 00=AND, 01=OR, 10=XOR, 11=NAND; latched on accepted start.
vld  input  1  current in1/in2/out_obs form a valid sample.
in1  input  1  applied gate input a.
in2  input  1  applied gate input b.
out_obs  input  1  observed gate output.
busy  output  1  high in CHECK state.
done  output  1  high in DONE state.
pass  output  1  verdict; valid only while done=1.
err_cnt  output  ERR_W  mismatch count, saturates at all-ones.
cov  output  4  coverage bitmap; bit index = {in1,in2}.
fail_vld  output  1  a first failure has been captured.
fail_vec  output  2  {in1,in2} of first mismatch.
fail_obs  output  1  out_obs of first mismatch.

Behaviour:
- Async reset: state=IDLE; busy=0, done=0, pass=0, err_cnt=0, cov=0, fail_vld=0, fail_vec=0, fail_obs=0; latched func=AND.
- States are IDLE, CHECK and DONE.
- IDLE: start=1 -> CHECK next edge; clear err_cnt, cov, fail_*, pass; latch func_sel. vld is ignored.
- CHECK, per sample (vld=1 at edge n):
  - exp = f(in1,in2) per latched func.
  - cov[{in1,in2}] set at edge n.
  - If out_obs != exp: err_cnt increments (holds at 2^ERR_W-1). If fail_vld=0, capture fail_vec={in1,in2} and fail_obs=out_obs, and set fail_vld.
  - All updates are visible in the cycle after edge n (1-cycle latency).
- CHECK -> DONE on the edge where cov becomes 4'b1111 (including that sample's bit):
  - done=1 and busy=0 in the following cycle.
  - pass = 1 iff err_cnt after that sample's update is 0. The final sample's mismatch counts.
- Repeated vectors before full coverage are legal: each is checked and counted; coverage is unchanged.
- start during CHECK is ignored; no restart, no clear.
- DONE:
  - Outputs hold; vld is ignored.
  - start=1 -> CHECK with the same clearing and latching as from IDLE.
  - done drops the cycle after start is accepted.
- vld=0 cycles in CHECK: no change. No timeout.
- rst asserted mid-run (any state): immediate async return to reset values; the run is abandoned.
- func_sel changes during CHECK have no effect.

Test Plan:
- AND, start, then vld samples 00/0, 01/0, 10/0, 11/1 on consecutive cycles -> cov steps 0001, 0011, 0111, 1111. done=1 one cycle after the 4th sample; pass=1, err_cnt=0, fail_vld=0.
- AND, samples 00/0, 01/0, 10/0, 11/0 (stuck-at-0) -> done=1, pass=0, err_cnt=1, fail_vld=1, fail_vec=11, fail_obs=0.
- XOR, samples 00/1, 01/0, 00/0, 10/1, 11/0 -> err_cnt=2, fail_vec=00, fail_obs=1. done only after the 5th sample (cov=1111); pass=0.
- ERR_W=2, NAND, six mismatching samples covering all combos -> err_cnt saturates at 3, pass=0; fail_* holds the first mismatch.
- Mid-CHECK: assert rst after 2 samples -> all outputs return to reset values without waiting for a clock edge. A second start during CHECK (no rst) is ignored: cov is not cleared.
- After DONE, pulse start with func_sel=OR, then samples 00/0, 01/1, 10/1, 11/1 -> previous results are cleared and the new run gives pass=1.
